// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_stage
// Brief   : MEM-stage load/store unit driving a word-addressed req/ready bus.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_BUSY = 2'd1;
    localparam logic [1:0]  c_DONE = 2'd2;
    localparam logic [15:0] c_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [15:0] r_count;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;

    logic        w_load;
    logic        w_access;
    logic        w_legal;
    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_load   = (ResultSrcM == 2'b01);
    assign w_access = MemWriteM | w_load;

    always_comb begin
        w_legal = 1'b0;
        case (funct3M)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~MemWriteM;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misalign = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                        ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));

    assign w_start = (r_state == c_IDLE) && w_access && w_legal && !w_misalign;

    // Gated by rst_n so the pipeline is released the moment reset asserts
    assign StallM = rst_n & (w_start | (r_state == c_BUSY));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ALUResultM[1:0];
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

    // Lane selection uses the offset captured at request time, not the live address
    always_comb begin
        case (r_offset)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_count   <= 16'h0;
            r_funct3  <= 3'b000;
            r_offset  <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            ReadDataM <= 32'h0;
            MisalignM <= 1'b0;
            BusErrM   <= 1'b0;
        end else begin
            MisalignM <= 1'b0;
            BusErrM   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        if (!w_legal) begin
                            BusErrM   <= 1'b1;
                            ReadDataM <= 32'h0;
                            r_state   <= c_DONE;
                        end else if (w_misalign) begin
                            MisalignM <= 1'b1;
                            ReadDataM <= 32'h0;
                            r_state   <= c_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWriteM;
                            mem_addr  <= {ALUResultM[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                            r_funct3  <= funct3M;
                            r_offset  <= ALUResultM[1:0];
                            r_count   <= 16'h0;
                            r_state   <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadDataM <= w_load_data;
                        end
                        r_state <= c_DONE;
                    end else if (r_count == c_LAST) begin
                        mem_req   <= 1'b0;
                        ReadDataM <= 32'h0;
                        BusErrM   <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_count <= r_count + 16'h1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_stage
// Brief   : Directed self-checking bench for lsu_mem_stage (timeout = 4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        BusErrM;

    int n_vec;
    int n_err;

    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;
    int          cap_unstable;
    int          stalls;
    int          reqs;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        MemWriteM  = we;
        ResultSrcM = we ? 2'b00 : 2'b01;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    // Runs one access; mem_ready is raised on BUSY cycle `lat` (0 = never).
    // Returns in the first non-stalled cycle (DONE) with inputs withdrawn.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int lat);
        bit done;
        int guard;
        drive(we, f3, addr, wd);
        #1;
        stalls = 0;
        reqs = 0;
        cap_unstable = 0;
        done = 1'b0;
        guard = 0;
        while (!done) begin
            if (StallM) stalls++;
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    cap_addr  = mem_addr;
                    cap_be    = mem_be;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_be !== cap_be ||
                             mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    cap_unstable++;
                end
            end
            if (!StallM) begin
                done = 1'b1;
            end else begin
                mem_ready = mem_req && (reqs == lat);
                mem_rdata = mem_ready ? rd : 32'h0;
                tick();
                guard++;
                if (guard > 40) begin
                    check_eq("stall_bound", 32'(guard), 32'd40);
                    done = 1'b1;
                end
            end
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        drive_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        drive_idle();
        repeat (3) tick();

        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_be", 32'(mem_be), 32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", ReadDataM, 32'h0);
        check_eq("rst_flags", {30'h0, MisalignM, BusErrM}, 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_stall", 32'(StallM), 32'd0);

        // LW 0x100, ready on first BUSY cycle
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        check_eq("lw_addr", cap_addr, 32'h100);
        check_eq("lw_be", 32'(cap_be), 32'hF);
        check_eq("lw_we", 32'(cap_we), 32'd0);
        check_eq("lw_stalls", 32'(stalls), 32'd2);
        check_eq("lw_data", ReadDataM, 32'hDEADBEEF);
        check_eq("lw_req_done", 32'(mem_req), 32'd0);
        tick();

        // LB / LBU at 0x203
        run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 1);
        check_eq("lb_addr", cap_addr, 32'h200);
        check_eq("lb_be", 32'(cap_be), 32'h8);
        check_eq("lb_data", ReadDataM, 32'hFFFFFF80);
        tick();
        run_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 1);
        check_eq("lbu_data", ReadDataM, 32'h00000080);
        tick();

        // SH 0x302, ready after 3 BUSY cycles; ReadDataM keeps 0x80
        run_access(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'hFFFFFFFF, 3);
        check_eq("sh_we", 32'(cap_we), 32'd1);
        check_eq("sh_be", 32'(cap_be), 32'hC);
        check_eq("sh_wdata_hi", {16'h0, cap_wdata[31:16]}, 32'hABCD);
        check_eq("sh_reqs", 32'(reqs), 32'd3);
        check_eq("sh_stalls", 32'(stalls), 32'd4);
        check_eq("sh_stable", 32'(cap_unstable), 32'd0);
        check_eq("sh_rdata_hold", ReadDataM, 32'h00000080);
        tick();

        // Misaligned LW 0x101
        drive(1'b0, 3'b010, 32'h101, 32'h0);
        #1;
        check_eq("mis_stall", 32'(StallM), 32'd0);
        tick();
        check_eq("mis_pulse", 32'(MisalignM), 32'd1);
        check_eq("mis_req", 32'(mem_req), 32'd0);
        check_eq("mis_rdata", ReadDataM, 32'h0);
        drive_idle();
        tick();
        check_eq("mis_pulse_end", 32'(MisalignM), 32'd0);

        // SW 0x104 proceeds normally
        run_access(1'b1, 3'b010, 32'h104, 32'h12345678, 32'h0, 2);
        check_eq("sw_addr", cap_addr, 32'h104);
        check_eq("sw_be", 32'(cap_be), 32'hF);
        check_eq("sw_wdata", cap_wdata, 32'h12345678);
        check_eq("sw_stalls", 32'(stalls), 32'd3);
        tick();

        // LHU / LH at 0x402
        run_access(1'b0, 3'b101, 32'h402, 32'h0, 32'hF00D1234, 1);
        check_eq("lhu_be", 32'(cap_be), 32'hC);
        check_eq("lhu_data", ReadDataM, 32'h0000F00D);
        tick();
        run_access(1'b0, 3'b001, 32'h402, 32'h0, 32'hF00D1234, 1);
        check_eq("lh_data", ReadDataM, 32'hFFFFF00D);
        tick();

        // Unsupported funct3 on a load
        drive(1'b0, 3'b011, 32'h0, 32'h0);
        #1;
        check_eq("unsup_stall", 32'(StallM), 32'd0);
        tick();
        check_eq("unsup_pulse", {30'h0, MisalignM, BusErrM}, 32'h1);
        check_eq("unsup_rdata", ReadDataM, 32'h0);
        drive_idle();
        tick();

        // Load to give ReadDataM a nonzero value before the timeout
        run_access(1'b0, 3'b010, 32'h140, 32'h0, 32'h11223344, 2);
        check_eq("lw2_data", ReadDataM, 32'h11223344);
        tick();

        // Timeout: never ready
        run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 0);
        check_eq("to_reqs", 32'(reqs), 32'd4);
        check_eq("to_stalls", 32'(stalls), 32'd5);
        check_eq("to_buserr", 32'(BusErrM), 32'd1);
        check_eq("to_rdata", ReadDataM, 32'h0);
        check_eq("to_req_low", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        tick();
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check_eq("late_rdy_rdata", ReadDataM, 32'h0);
        check_eq("late_rdy_flags", {29'h0, mem_req, StallM, BusErrM}, 32'h0);

        // Reset asserted mid-BUSY
        drive(1'b0, 3'b010, 32'h600, 32'h0);
        #1;
        tick();
        tick();
        check_eq("rb_req_busy", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rb_req_async", 32'(mem_req), 32'd0);
        check_eq("rb_stall_async", 32'(StallM), 32'd0);
        drive_idle();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rb_no_pulse", {29'h0, mem_req, MisalignM, BusErrM}, 32'h0);
        run_access(1'b0, 3'b010, 32'h700, 32'h0, 32'hCAFEF00D, 1);
        check_eq("rb_lw_stalls", 32'(stalls), 32'd2);
        check_eq("rb_lw_addr", cap_addr, 32'h700);
        check_eq("rb_lw_data", ReadDataM, 32'hCAFEF00D);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs (address, store data, funct3, control), drives a word-addressed request/ready data-memory bus, and stalls the pipeline until the access completes. It returns aligned, sign- or zero-extended load data to the MEM/WB register. It is the consumer end of the EX/MEM interface and sits between that register and data memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for mem_ready before a bus error is declared (1..65535).

Ports:
clk  input  1  clock, all state updated on rising edge
rst_n  input  1  asynchronous active-low reset
MemWriteM  input  1  store in MEM stage
ResultSrcM  input  2  2'b01 = load in MEM stage
funct3M  input  3  access size/sign
ALUResultM  input  32  byte address
WriteDataM  input  32  store data (LSB-aligned)
mem_req  output  1  bus request, held until mem_ready
mem_we  output  1  1 = write
mem_addr  output  32  word address (byte address with [1:0] = 0)
mem_be  output  4  byte enables
mem_wdata  output  32  lane-shifted store data
mem_ready  input  1  access complete this cycle
mem_rdata  input  32  read word, valid when mem_ready=1
StallM  output  1  freeze IF..MEM, bubble WB
ReadDataM  output  32  formatted load result
MisalignM  output  1  one-cycle pulse: misaligned access dropped
BusErrM  output  1  one-cycle pulse: timeout or unsupported funct3

Behaviour:
- Access = MemWriteM | (ResultSrcM==2'b01). MemWriteM has priority if both are set.
- Legal funct3 values for loads are 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU. Legal values for stores are 000, 001 and 010. Any other value is unsupported.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states are IDLE, BUSY and DONE.
- IDLE, legal aligned access: StallM=1 combinationally. On the next edge, latch mem_addr, mem_be, mem_wdata, mem_we, funct3 and addr[1:0]; set mem_req=1; go to BUSY.
- IDLE, misaligned or unsupported access: no request and StallM=0. The FSM goes to DONE, and on that edge MisalignM or BusErrM is registered high for one cycle. ReadDataM is set to 0.
- BUSY: StallM=1 and mem_req=1, and the bus outputs stay stable. The wait counter increments each cycle.
- BUSY, mem_ready=1: on that edge mem_req goes to 0 and the FSM goes to DONE. For loads, ReadDataM is loaded with the formatted mem_rdata; for stores, ReadDataM is unchanged.
- BUSY, counter reaches TIMEOUT_CYCLES without mem_ready: mem_req goes to 0, ReadDataM goes to 0, BusErrM pulses, and the FSM goes to DONE. A late mem_ready arriving after this is ignored.
- DONE: StallM=0 so the pipeline advances on this edge. Next state is IDLE unconditionally. A new access is never started from DONE.
- Byte enables: SB gives 4'b0001<<addr[1:0]. SH gives 4'b0011<<addr[1:0]. SW gives 4'b1111.
- mem_wdata = WriteDataM replicated into the addressed lane(s).
- Load format: select byte or halfword by the latched offset. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Minimum latency: an access takes IDLE, then BUSY with mem_ready=1 on the first BUSY cycle, then DONE. That is 2 stall cycles, and ReadDataM is valid in DONE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, ReadDataM=0, MisalignM=0, BusErrM=0, state=IDLE, counter=0. StallM is 0 in IDLE with no access.
- Reset asserted mid-BUSY: mem_req drops immediately (asynchronous). The access is abandoned with no pulse.
- Non-access instructions pass through: StallM=0 and ReadDataM holds its previous value.

Test Plan:
- LW at 0x100, mem_ready on the first BUSY cycle, rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'hF, mem_we=0, StallM high for 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- LB at 0x203, rdata=0x80FF_FFFF -> mem_addr=0x200, mem_be=4'b1000, ReadDataM=0xFFFFFF80. Same access as LBU -> ReadDataM=0x00000080.
- SH at 0x302 with WriteDataM=0x0000ABCD, mem_ready after 3 BUSY cycles -> mem_we=1, mem_be=4'b1100, mem_wdata[31:16]=0xABCD, mem_req held for exactly 3 cycles, StallM high for 4 cycles.
- LW at 0x101 -> no mem_req, MisalignM=1 for exactly one cycle, StallM=0. An SW to 0x104 on the next access proceeds normally.
- TIMEOUT_CYCLES=4 with mem_ready tied low -> mem_req drops after 4 BUSY cycles, BusErrM pulses, ReadDataM=0, FSM returns to IDLE.
- rst_n pulsed low during BUSY -> mem_req=0 and StallM=0 asynchronously. After release, the FSM is in IDLE and a fresh LW completes normally.
